jk_ff_bank: RTL and testbench

- Parametrised, multi-mode register bank. It generalises the single-bit JK flip-flop to WIDTH bits with per-bit enables.
- Selectable JK, D, T or SR behaviour, plus whole-vector up/down counting.
- Adds parallel load, a change mask, a wrap pulse and a sticky SR-illegal flag.
- Serves as the general storage/counter primitive for later control blocks in the codebase.

---
 rtl/jk_ff_bank_pkg.sv | 15 +
 rtl/ff_bit_cell.sv | 36 +++
 rtl/jk_ff_bank.sv | 103 ++++++++++
 tb/tb_jk_ff_bank.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/jk_ff_bank_pkg.sv
// Shared mode encoding for the jk_ff_bank register bank and its per-bit cell.
package jk_ff_bank_pkg;

  typedef enum logic [2:0] {
    MODE_JK   = 3'd0,
    MODE_D    = 3'd1,
    MODE_T    = 3'd2,
    MODE_SR   = 3'd3,
    MODE_UP   = 3'd4,
    MODE_DN   = 3'd5,
    MODE_RSV6 = 3'd6,
    MODE_RSV7 = 3'd7
  } mode_e;

endpackage

// File: rtl/ff_bit_cell.sv
// One bit of the bank: next-state for the bitwise modes (JK/D/T/SR).
// Counter and reserved modes hold here; the top level owns whole-vector ops.
module ff_bit_cell
  import jk_ff_bank_pkg::*;
(
  input  mode_e mode,
  input  logic  en,
  input  logic  j,
  input  logic  k,
  input  logic  q,
  output logic  q_nxt,
  output logic  sr_illegal
);

  always_comb begin
    q_nxt      = q;
    sr_illegal = 1'b0;
    if (en) begin
      case (mode)
        MODE_JK: q_nxt = (j & ~q) | (~k & q);
        MODE_D:  q_nxt = j;
        MODE_T:  q_nxt = q ^ j;
        MODE_SR: begin
          case ({j, k})
            2'b10:   q_nxt = 1'b1;
            2'b01:   q_nxt = 1'b0;
            2'b11:   sr_illegal = 1'b1;
            default: q_nxt = q;
          endcase
        end
        default: q_nxt = q;
      endcase
    end
  end

endmodule

// File: rtl/jk_ff_bank.sv
// Multi-mode register bank: per-bit JK/D/T/SR cells plus up/down counting,
// parallel load, change mask, wrap pulse and sticky SR-illegal flag.
module jk_ff_bank
  import jk_ff_bank_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] changed,
  output logic             carry_out,
  output logic             sr_err
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  mode_e            mode_s;
  logic [WIDTH-1:0] cell_nxt;
  logic [WIDTH-1:0] cell_ill;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qn_q, qn_d;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic             carry_q, carry_d;
  logic             sr_err_q, sr_err_d;
  logic             sr_set;

  assign mode_s = mode_e'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_bit_cell u_cell (
      .mode       (mode_s),
      .en         (en[i]),
      .j          (j[i]),
      .k          (k[i]),
      .q          (q_q[i]),
      .q_nxt      (cell_nxt[i]),
      .sr_illegal (cell_ill[i])
    );
  end

  always_comb begin
    q_d     = q_q;
    carry_d = 1'b0;
    sr_set  = 1'b0;
    if (load) begin
      q_d = load_val;
    end else begin
      case (mode_s)
        MODE_JK, MODE_D, MODE_T, MODE_SR: begin
          q_d    = cell_nxt;
          sr_set = |cell_ill;
        end
        MODE_UP: if (en[0]) begin
          q_d     = q_q + 1'b1;
          carry_d = (q_q == ALL_ONES);
        end
        MODE_DN: if (en[0]) begin
          q_d     = q_q - 1'b1;
          carry_d = (q_q == '0);
        end
        default: q_d = q_q;
      endcase
    end
    // A fresh illegal event outranks a simultaneous clear.
    sr_err_d  = sr_set | (sr_err_q & ~err_clr);
    qn_d      = ~q_d;
    changed_d = q_d ^ q_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= RST_VAL;
      qn_q      <= ~RST_VAL;
      changed_q <= '0;
      carry_q   <= 1'b0;
      sr_err_q  <= 1'b0;
    end else begin
      q_q       <= q_d;
      qn_q      <= qn_d;
      changed_q <= changed_d;
      carry_q   <= carry_d;
      sr_err_q  <= sr_err_d;
    end
  end

  assign q         = q_q;
  assign qn        = qn_q;
  assign changed   = changed_q;
  assign carry_out = carry_q;
  assign sr_err    = sr_err_q;

endmodule

// File: tb/tb_jk_ff_bank.sv
// Scoreboard bench for jk_ff_bank (WIDTH=4, RST_VAL=A): directed scenarios then random traffic.
module tb_jk_ff_bank;
  localparam int W = 4;
  localparam logic [W-1:0] RV = 4'hA;

  logic         clk = 1'b0;
  logic         rst, load, err_clr;
  logic [2:0]   mode;
  logic [W-1:0] en, j, k, load_val;
  logic [W-1:0] q, qn, changed;
  logic         carry_out, sr_err;

  jk_ff_bank #(.WIDTH(W), .RST_VAL(RV)) dut (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .j(j), .k(k),
    .load(load), .load_val(load_val), .err_clr(err_clr),
    .q(q), .qn(qn), .changed(changed), .carry_out(carry_out), .sr_err(sr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] qn;
    logic [W-1:0] ch;
    logic         c;
    logic         e;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0, cyc = 0;

  // reference state kept as plain integers
  int m_q = 0, m_err = 0;

  task automatic model(input logic r, input logic ld, input int lv, input int md,
                       input int e, input int jj, input int kk, input logic clr);
    int nq, c, set;
    exp_t x;
    nq = m_q; c = 0; set = 0;
    if (r) begin
      nq = RV; m_err = 0;
      x.q = nq[W-1:0]; x.qn = ~x.q; x.ch = '0; x.c = 0; x.e = 0;
      m_q = nq; exp_q.push_back(x);
      return;
    end
    if (ld) nq = lv;
    else if (md <= 3) begin
      for (int b = 0; b < W; b++) begin
        int qb, jb, kb;
        if (((e >> b) & 1) == 0) continue;
        qb = (m_q >> b) & 1; jb = (jj >> b) & 1; kb = (kk >> b) & 1;
        case (md)
          0: qb = (jb && kb) ? 1 - qb : (jb ? 1 : (kb ? 0 : qb));
          1: qb = jb;
          2: qb = jb ? 1 - qb : qb;
          default: begin
            if (jb && kb) set = 1;
            else if (jb) qb = 1;
            else if (kb) qb = 0;
          end
        endcase
        nq = (nq & ~(1 << b)) | (qb << b);
      end
    end else if (md == 4 && (e & 1)) begin
      nq = (m_q + 1) % (1 << W); c = (m_q == (1 << W) - 1);
    end else if (md == 5 && (e & 1)) begin
      nq = (m_q + (1 << W) - 1) % (1 << W); c = (m_q == 0);
    end
    m_err = set ? 1 : (clr ? 0 : m_err);
    x.q = nq[W-1:0]; x.qn = ~x.q; x.ch = x.q ^ m_q[W-1:0];
    x.c = c[0]; x.e = m_err[0];
    m_q = nq;
    exp_q.push_back(x);
  endtask

  task automatic step(input logic r, input logic ld, input int lv, input int md,
                      input int e, input int jj, input int kk, input logic clr);
    @(negedge clk);
    rst = r; load = ld; load_val = lv[W-1:0]; mode = md[2:0];
    en = e[W-1:0]; j = jj[W-1:0]; k = kk[W-1:0]; err_clr = clr;
    model(r, ld, lv, md, e, jj, kk, clr);
  endtask

  // monitor: every edge presents a result one cycle after its stimulus
  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      exp_t x, a;
      x = exp_q.pop_front();
      a = {q, qn, changed, carry_out, sr_err};
      checks++;
      if (a !== x) begin
        errors++;
        $display("FAIL cycle%0d q/qn/changed/carry/sr_err got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b",
                 cyc, a.q, a.qn, a.ch, a.c, a.e, x.q, x.qn, x.ch, x.c, x.e);
      end
    end
  end

  initial begin
    rst = 1; load = 0; load_val = 0; mode = 0; en = 0; j = 0; k = 0; err_clr = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // JK full enable then single-bit enable
    step(0, 1, 4'b0110, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 4'hF, 4'b1100, 4'b1010, 0);
    step(0, 1, 4'b0110, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 4'b0001, 4'b1100, 4'b1010, 0);
    // T toggles
    step(0, 1, 4'h3, 2, 0, 0, 0, 0);
    step(0, 0, 0, 2, 4'hF, 4'hF, 0, 0);
    step(0, 0, 0, 2, 4'hF, 4'hF, 0, 0);
    // SR illegal, sticky, set-beats-clear, clear
    step(0, 0, 0, 3, 4'hF, 4'b0100, 4'b0100, 0);
    repeat (3) step(0, 0, 0, 3, 4'hF, 0, 0, 0);
    step(0, 0, 0, 3, 4'hF, 4'b0100, 4'b0100, 1);
    step(0, 0, 0, 3, 4'hF, 0, 0, 1);
    // disabled bit cannot raise sr_err; load masks sr_err set
    step(0, 0, 0, 3, 4'b1011, 4'b0100, 4'b0100, 0);
    step(0, 1, 4'h5, 3, 4'hF, 4'hF, 4'hF, 0);
    // count up across wrap, count down across wrap
    step(0, 1, 4'hE, 4, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 4, 4'b0001, 0, 0, 0);
    step(0, 1, 4'h1, 5, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 5, 4'b0001, 0, 0, 0);
    step(0, 0, 0, 5, 4'b1110, 0, 0, 0);
    // load wins over count, then wrap, then reset aborts a wrap
    step(0, 1, 4'hF, 4, 4'b0001, 0, 0, 0);
    step(0, 0, 0, 4, 4'b0001, 0, 0, 0);
    step(0, 1, 4'hF, 4, 4'b0001, 0, 0, 0);
    step(1, 0, 0, 4, 4'b0001, 0, 0, 0);
    // reserved modes hold
    step(0, 0, 0, 6, 4'hF, 4'hF, 4'hF, 0);
    step(0, 0, 0, 7, 4'hF, 4'hF, 0, 0);
    // random traffic
    for (int n = 0; n < 400; n++) begin
      int md, jj, kk;
      md = $urandom_range(0, 7);
      jj = $urandom_range(0, 15);
      kk = ($urandom_range(0, 3) == 0) ? jj : $urandom_range(0, 15);
      step($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15),
           md, $urandom_range(0, 15), jj, kk, $urandom_range(0, 3) == 0);
    end
    step(0, 0, 0, 6, 0, 0, 0, 0);
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain outstanding=%0d want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
